axi_sram_responder: RTL and testbench

// - AXI4 responder (slave) backed by on-chip SRAM; the device-side end of tl_axi_adapter.
// - Stands in for the DDR controller in simulation and small FPGA builds.
// - Same AXI channel structs as the DDR path, so it drops in behind tl_axi_adapter unchanged.
// - Independent read and write engines; one outstanding burst per direction.

---
 rtl/axi_sram_responder_if.sv | 63 ++++++
 rtl/axi_sram_responder.sv | 180 ++++++++++++++++++
 tb/tb_axi_sram_responder.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_sram_responder_if.sv
// AXI4 channel bundle for axi_sram_responder: valid/ready pairs plus packed payload structs.
// The slave modport is the responder side; the master modport is the requester side.
interface axi_sram_responder_if #(
  parameter int DataWidth = 128,
  parameter int AddrWidth = 16,
  parameter int IdWidth   = 8
);
  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
  } ax_t;

  typedef struct packed {
    logic [DataWidth-1:0]   data;
    logic [DataWidth/8-1:0] strb;
    logic                   last;
  } w_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [1:0]         resp;
  } b_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    logic [1:0]           resp;
    logic                 last;
  } r_t;

  logic axi_aw_valid;
  logic axi_aw_ready;
  ax_t  axi_aw;
  logic axi_w_valid;
  logic axi_w_ready;
  w_t   axi_w;
  logic axi_b_valid;
  logic axi_b_ready;
  b_t   axi_b;
  logic axi_ar_valid;
  logic axi_ar_ready;
  ax_t  axi_ar;
  logic axi_r_valid;
  logic axi_r_ready;
  r_t   axi_r;

  modport slave (
    input  axi_aw_valid, axi_aw, axi_w_valid, axi_w, axi_b_ready,
    input  axi_ar_valid, axi_ar, axi_r_ready,
    output axi_aw_ready, axi_w_ready, axi_b_valid, axi_b,
    output axi_ar_ready, axi_r_valid, axi_r
  );

  modport master (
    output axi_aw_valid, axi_aw, axi_w_valid, axi_w, axi_b_ready,
    output axi_ar_valid, axi_ar, axi_r_ready,
    input  axi_aw_ready, axi_w_ready, axi_b_valid, axi_b,
    input  axi_ar_ready, axi_r_valid, axi_r
  );
endinterface

// File: rtl/axi_sram_responder.sv
// AXI4 slave backed by a read-first byte-writable SRAM; independent single-burst read and write engines.
// Define AXI_SRAM_WRAP_EN to support WRAP bursts; otherwise WRAP is answered like the reserved burst type.
module axi_sram_responder #(
  parameter int DataWidth = 128,
  parameter int AddrWidth = 16,
  parameter int IdWidth   = 8
) (
  input logic                 clk_i,
  input logic                 rst_i,
  axi_sram_responder_if.slave axi
);
  localparam int StrbW = DataWidth / 8;
  localparam int OffW  = $clog2(StrbW);
  localparam int WordW = AddrWidth - OffW;
  localparam int Words = 2 ** WordW;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;

`ifdef AXI_SRAM_WRAP_EN
  localparam logic WrapEn = 1'b1;
`else
  localparam logic WrapEn = 1'b0;
`endif

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_e;

  // WRAP address math is harmless when WRAP is disabled: such bursts never touch memory.
  function automatic logic [AddrWidth-1:0] f_next_addr(input logic [AddrWidth-1:0] addr,
                                                       input logic [7:0] len,
                                                       input logic [2:0] size,
                                                       input logic [1:0] burst);
    logic [AddrWidth-1:0] step;
    logic [AddrWidth-1:0] mask;
    step = AddrWidth'(1) << size;
    mask = ((AddrWidth'(len) + AddrWidth'(1)) << size) - AddrWidth'(1);
    case (burst)
      BurstIncr: f_next_addr = addr + step;
      BurstWrap: f_next_addr = (addr & ~mask) | ((addr + step) & mask);
      default:   f_next_addr = addr;
    endcase
  endfunction

  function automatic logic f_burst_err(input logic [1:0] burst);
    f_burst_err = (burst == 2'b11) || ((burst == BurstWrap) && !WrapEn);
  endfunction

  wstate_e r_wstate, w_wstate_next;
  rstate_e r_rstate, w_rstate_next;

  logic [IdWidth-1:0]   r_wid, r_rid;
  logic [AddrWidth-1:0] r_waddr, r_raddr;
  logic [7:0]           r_wlen, r_rlen, r_rcnt;
  logic [2:0]           r_wsize, r_rsize;
  logic [1:0]           r_wburst, r_rburst;
  logic                 r_werr, r_rerr;

  logic [DataWidth-1:0] r_mem [Words];
  logic [DataWidth-1:0] r_rdata;
  logic [StrbW-1:0]     w_lane_we;

  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_we, w_re, w_r_last;

  assign w_aw_hs  = axi.axi_aw_valid && (r_wstate == W_IDLE);
  assign w_w_hs   = axi.axi_w_valid  && (r_wstate == W_DATA);
  assign w_b_hs   = axi.axi_b_ready  && (r_wstate == W_RESP);
  assign w_ar_hs  = axi.axi_ar_valid && (r_rstate == R_IDLE);
  assign w_r_hs   = axi.axi_r_ready  && (r_rstate == R_DATA);
  assign w_we     = w_w_hs && !r_werr;
  assign w_re     = (r_rstate == R_FETCH);
  assign w_r_last = (r_rcnt == 8'd0);

  generate
    for (genvar gi = 0; gi < StrbW; gi++) begin : g_lane_we
      assign w_lane_we[gi] = w_we && axi.axi_w.strb[gi];
    end
  endgenerate

  // No reset here so contents survive a reset; read and write share one block to get read-first.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < StrbW; b++) begin
      if (w_lane_we[b]) begin
        r_mem[r_waddr[AddrWidth-1:OffW]][b*8 +: 8] <= axi.axi_w.data[b*8 +: 8];
      end
    end
    if (w_re) begin
      r_rdata <= r_mem[r_raddr[AddrWidth-1:OffW]];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
    end else begin
      r_wstate <= w_wstate_next;
      r_rstate <= w_rstate_next;
    end
  end

  always_comb begin
    w_wstate_next = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_aw_hs) w_wstate_next = W_DATA;
      W_DATA:  if (w_w_hs && axi.axi_w.last) w_wstate_next = W_RESP;
      W_RESP:  if (w_b_hs) w_wstate_next = W_IDLE;
      default: w_wstate_next = W_IDLE;
    endcase
  end

  always_comb begin
    w_rstate_next = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_next = R_FETCH;
      R_FETCH: w_rstate_next = R_DATA;
      R_DATA:  if (w_r_hs) w_rstate_next = w_r_last ? R_IDLE : R_FETCH;
      default: w_rstate_next = R_IDLE;
    endcase
  end

  always_comb begin
    axi.axi_aw_ready = (r_wstate == W_IDLE);
    axi.axi_w_ready  = (r_wstate == W_DATA);
    axi.axi_b_valid  = (r_wstate == W_RESP);
    axi.axi_b.id     = r_wid;
    axi.axi_b.resp   = r_werr ? RespSlvErr : RespOkay;
    axi.axi_ar_ready = (r_rstate == R_IDLE);
    axi.axi_r_valid  = (r_rstate == R_DATA);
    axi.axi_r.id     = r_rid;
    axi.axi_r.data   = ((r_rstate == R_DATA) && !r_rerr) ? r_rdata : '0;
    axi.axi_r.resp   = r_rerr ? RespSlvErr : RespOkay;
    axi.axi_r.last   = (r_rstate == R_DATA) && w_r_last;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wid    <= '0;
      r_waddr  <= '0;
      r_wlen   <= '0;
      r_wsize  <= '0;
      r_wburst <= '0;
      r_werr   <= 1'b0;
    end else if (w_aw_hs) begin
      r_wid    <= axi.axi_aw.id;
      r_waddr  <= axi.axi_aw.addr[AddrWidth-1:0];
      r_wlen   <= axi.axi_aw.len;
      r_wsize  <= axi.axi_aw.size;
      r_wburst <= axi.axi_aw.burst;
      r_werr   <= f_burst_err(axi.axi_aw.burst);
    end else if (w_w_hs) begin
      r_waddr  <= f_next_addr(r_waddr, r_wlen, r_wsize, r_wburst);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rid    <= '0;
      r_raddr  <= '0;
      r_rlen   <= '0;
      r_rcnt   <= '0;
      r_rsize  <= '0;
      r_rburst <= '0;
      r_rerr   <= 1'b0;
    end else if (w_ar_hs) begin
      r_rid    <= axi.axi_ar.id;
      r_raddr  <= axi.axi_ar.addr[AddrWidth-1:0];
      r_rlen   <= axi.axi_ar.len;
      r_rcnt   <= axi.axi_ar.len;
      r_rsize  <= axi.axi_ar.size;
      r_rburst <= axi.axi_ar.burst;
      r_rerr   <= f_burst_err(axi.axi_ar.burst);
    end else if (w_r_hs) begin
      r_raddr  <= f_next_addr(r_raddr, r_rlen, r_rsize, r_rburst);
      r_rcnt   <= r_rcnt - 8'd1;
    end
  end
endmodule

// File: tb/tb_axi_sram_responder.sv
// Directed bench for axi_sram_responder: single/INCR/strobe, R backpressure, reserved and WRAP bursts, mid-burst reset.
// WRAP expectations follow AXI_SRAM_WRAP_EN when it is defined for the build.
module tb_axi_sram_responder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_sram_responder_if #(.DataWidth(128), .AddrWidth(16), .IdWidth(8)) axi ();

  axi_sram_responder #(.DataWidth(128), .AddrWidth(16), .IdWidth(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .axi   (axi)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [127:0] wbeat    [16];
  logic [15:0]  wstrb    [16];
  logic [127:0] exp_beat [16];
  logic [1:0]   exp_rresp;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       sig = axi.axi_aw_ready;
      1:       sig = axi.axi_w_ready;
      2:       sig = axi.axi_b_valid;
      3:       sig = axi.axi_ar_ready;
      4:       sig = axi.axi_r_valid;
      default: sig = 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int which, input string tag, output int n);
    n = 0;
    while (!sig(which) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, sig(which), 1'b1);
  endtask

  task automatic do_write(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [1:0] exp_resp);
    int n;
    axi.axi_aw.id    = id;
    axi.axi_aw.addr  = addr;
    axi.axi_aw.len   = len;
    axi.axi_aw.size  = size;
    axi.axi_aw.burst = burst;
    axi.axi_aw_valid = 1'b1;
    wait_for(0, "aw_ready", n);
    @(posedge clk); #1;
    axi.axi_aw_valid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      axi.axi_w.data  = wbeat[b];
      axi.axi_w.strb  = wstrb[b];
      axi.axi_w.last  = (b == int'(len));
      axi.axi_w_valid = 1'b1;
      wait_for(1, "w_ready", n);
      @(posedge clk); #1;
    end
    axi.axi_w_valid = 1'b0;
    axi.axi_w.last  = 1'b0;
    axi.axi_b_ready = 1'b1;
    wait_for(2, "b_valid", n);
    check("b_id", axi.axi_b.id, id);
    check("b_resp", axi.axi_b.resp, exp_resp);
    $display("WR id=%0d addr=0x%h len=%0d burst=%0d bresp=%0d", id, addr, len, burst, axi.axi_b.resp);
    @(posedge clk); #1;
    axi.axi_b_ready = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input int stall_beat, input int stall_cyc);
    int n;
    axi.axi_ar.id    = id;
    axi.axi_ar.addr  = addr;
    axi.axi_ar.len   = len;
    axi.axi_ar.size  = size;
    axi.axi_ar.burst = burst;
    axi.axi_ar_valid = 1'b1;
    wait_for(3, "ar_ready", n);
    @(posedge clk); #1;
    axi.axi_ar_valid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      wait_for(4, "r_valid", n);
      check($sformatf("r_latency[%0d]", b), n, 1);
      check($sformatf("r_data[%0d]", b), axi.axi_r.data, exp_beat[b]);
      check($sformatf("r_resp[%0d]", b), axi.axi_r.resp, exp_rresp);
      check($sformatf("r_last[%0d]", b), axi.axi_r.last, (b == int'(len)));
      check($sformatf("r_id[%0d]", b), axi.axi_r.id, id);
      for (int c = 0; b == stall_beat && c < stall_cyc; c++) begin
        @(posedge clk); #1;
        check($sformatf("r_hold_valid[%0d]", c), axi.axi_r_valid, 1'b1);
        check($sformatf("r_hold_data[%0d]", c), axi.axi_r.data, exp_beat[b]);
        check($sformatf("r_hold_last[%0d]", c), axi.axi_r.last, (b == int'(len)));
      end
      $display("RD id=%0d addr=0x%h beat=%0d data=%h resp=%0d last=%0d",
               id, addr, b, axi.axi_r.data, axi.axi_r.resp, axi.axi_r.last);
      axi.axi_r_ready = 1'b1;
      @(posedge clk); #1;
      axi.axi_r_ready = 1'b0;
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    axi.axi_aw_valid = 1'b0;
    axi.axi_w_valid  = 1'b0;
    axi.axi_b_ready  = 1'b0;
    axi.axi_ar_valid = 1'b0;
    axi.axi_r_ready  = 1'b0;
    axi.axi_aw = '0;
    axi.axi_w  = '0;
    axi.axi_ar = '0;
    for (int i = 0; i < 16; i++) wstrb[i] = 16'hFFFF;

    repeat (3) @(posedge clk);
    #1;
    check("rst_aw_ready", axi.axi_aw_ready, 1'b1);
    check("rst_ar_ready", axi.axi_ar_ready, 1'b1);
    check("rst_w_ready", axi.axi_w_ready, 1'b0);
    check("rst_b_valid", axi.axi_b_valid, 1'b0);
    check("rst_r_valid", axi.axi_r_valid, 1'b0);
    check("rst_b", axi.axi_b, '0);
    check("rst_r", axi.axi_r, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single beat write and readback
    wbeat[0] = 128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5;
    do_write(8'd3, 16'h0040, 8'd0, 3'd4, 2'b01, 2'b00);
    exp_beat[0] = 128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5;
    exp_rresp = 2'b00;
    do_read(8'd5, 16'h0040, 8'd0, 3'd4, 2'b01, -1, 0);

    // INCR burst, then overwrite with a partial strobe on beat 2
    wbeat[0] = 128'h1111_1111_1111_1111_1111_1111_1111_1111;
    wbeat[1] = 128'h2222_2222_2222_2222_2222_2222_2222_2222;
    wbeat[2] = 128'h3333_3333_3333_3333_3333_3333_3333_3333;
    wbeat[3] = 128'h4444_4444_4444_4444_4444_4444_4444_4444;
    do_write(8'd7, 16'h0100, 8'd3, 3'd4, 2'b01, 2'b00);
    wbeat[0] = 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA;
    wbeat[1] = 128'hBBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB;
    wbeat[2] = 128'hCCCC_CCCC_CCCC_CCCC_CCCC_CCCC_CCCC_CCCC;
    wbeat[3] = 128'hDDDD_DDDD_DDDD_DDDD_DDDD_DDDD_DDDD_DDDD;
    wstrb[2] = 16'h00FF;
    do_write(8'd8, 16'h0100, 8'd3, 3'd4, 2'b01, 2'b00);
    wstrb[2] = 16'hFFFF;
    exp_beat[0] = 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA;
    exp_beat[1] = 128'hBBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB;
    exp_beat[2] = 128'h3333_3333_3333_3333_CCCC_CCCC_CCCC_CCCC;
    exp_beat[3] = 128'hDDDD_DDDD_DDDD_DDDD_DDDD_DDDD_DDDD_DDDD;
    exp_rresp = 2'b00;
    do_read(8'd9, 16'h0100, 8'd3, 3'd4, 2'b01, 1, 5);

    // Reserved burst type
    wbeat[0] = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;
    do_write(8'd1, 16'h0200, 8'd0, 3'd4, 2'b01, 2'b00);
    wbeat[0] = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
    do_write(8'd2, 16'h0200, 8'd0, 3'd4, 2'b11, 2'b10);
    exp_beat[0] = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;
    exp_rresp = 2'b00;
    do_read(8'd3, 16'h0200, 8'd0, 3'd4, 2'b01, -1, 0);
    exp_beat[0] = 128'h0;
    exp_beat[1] = 128'h0;
    exp_rresp = 2'b10;
    do_read(8'd4, 16'h0200, 8'd1, 3'd4, 2'b11, -1, 0);

    // WRAP len=3 size=4 starting at 0x130
    wbeat[0] = 128'h5050_5050_5050_5050_5050_5050_5050_5050;
    wbeat[1] = 128'h6060_6060_6060_6060_6060_6060_6060_6060;
    wbeat[2] = 128'h7070_7070_7070_7070_7070_7070_7070_7070;
    wbeat[3] = 128'h8080_8080_8080_8080_8080_8080_8080_8080;
`ifdef AXI_SRAM_WRAP_EN
    do_write(8'd6, 16'h0130, 8'd3, 3'd4, 2'b10, 2'b00);
    exp_beat[0] = 128'h6060_6060_6060_6060_6060_6060_6060_6060;
    exp_beat[1] = 128'h7070_7070_7070_7070_7070_7070_7070_7070;
    exp_beat[2] = 128'h8080_8080_8080_8080_8080_8080_8080_8080;
    exp_beat[3] = 128'h5050_5050_5050_5050_5050_5050_5050_5050;
    exp_rresp = 2'b00;
    do_read(8'd10, 16'h0100, 8'd3, 3'd4, 2'b01, -1, 0);
    exp_beat[0] = 128'h5050_5050_5050_5050_5050_5050_5050_5050;
    exp_beat[1] = 128'h6060_6060_6060_6060_6060_6060_6060_6060;
    exp_beat[2] = 128'h7070_7070_7070_7070_7070_7070_7070_7070;
    exp_beat[3] = 128'h8080_8080_8080_8080_8080_8080_8080_8080;
    do_read(8'd11, 16'h0130, 8'd3, 3'd4, 2'b10, -1, 0);
`else
    do_write(8'd6, 16'h0130, 8'd3, 3'd4, 2'b10, 2'b10);
    exp_beat[0] = 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA;
    exp_beat[1] = 128'hBBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB;
    exp_beat[2] = 128'h3333_3333_3333_3333_CCCC_CCCC_CCCC_CCCC;
    exp_beat[3] = 128'hDDDD_DDDD_DDDD_DDDD_DDDD_DDDD_DDDD_DDDD;
    exp_rresp = 2'b00;
    do_read(8'd10, 16'h0100, 8'd3, 3'd4, 2'b01, -1, 0);
    for (int i = 0; i < 4; i++) exp_beat[i] = 128'h0;
    exp_rresp = 2'b10;
    do_read(8'd11, 16'h0130, 8'd3, 3'd4, 2'b10, -1, 0);
`endif

    // Reset pulse while beat 2 of a len=7 write is presented
    wbeat[0] = 128'h0101_0101_0101_0101_0101_0101_0101_0101;
    wbeat[1] = 128'h0202_0202_0202_0202_0202_0202_0202_0202;
    wbeat[2] = 128'h0303_0303_0303_0303_0303_0303_0303_0303;
    axi.axi_aw.id    = 8'd12;
    axi.axi_aw.addr  = 16'h0400;
    axi.axi_aw.len   = 8'd7;
    axi.axi_aw.size  = 3'd4;
    axi.axi_aw.burst = 2'b01;
    axi.axi_aw_valid = 1'b1;
    wait_for(0, "aw_ready_rst", n);
    @(posedge clk); #1;
    axi.axi_aw_valid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      axi.axi_w.data  = wbeat[b];
      axi.axi_w.strb  = 16'hFFFF;
      axi.axi_w.last  = 1'b0;
      axi.axi_w_valid = 1'b1;
      wait_for(1, "w_ready_rst", n);
      @(posedge clk); #1;
    end
    axi.axi_w.data = wbeat[2];
    rst = 1'b1;
    #1;
    check("midrst_b_valid", axi.axi_b_valid, 1'b0);
    check("midrst_w_ready", axi.axi_w_ready, 1'b0);
    axi.axi_w_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_aw_ready", axi.axi_aw_ready, 1'b1);
    @(posedge clk); #1;
    check("midrst_b_idle", axi.axi_b_valid, 1'b0);
    $display("RST mid-burst id=12 addr=0x0400 after 2 beats");
    exp_beat[0] = 128'h0101_0101_0101_0101_0101_0101_0101_0101;
    exp_beat[1] = 128'h0202_0202_0202_0202_0202_0202_0202_0202;
    exp_rresp = 2'b00;
    do_read(8'd13, 16'h0400, 8'd1, 3'd4, 2'b01, -1, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
